// File: rtl/iq_state_discriminator.sv
// iq_state_discriminator: I/Q projection, thresholding and batched excited-state counts into a FWFT FIFO; IQ_DISC_PROJ_TAP_EN adds a projection tap
module iq_state_discriminator #(
  parameter int INT_IN_DATA_WIDTH = 23,
  parameter int INT_WEIGHT_WIDTH = 16,
  parameter int INT_MAX_SHOTS = 1024,
  parameter int INT_FIFO_DEPTH = 16,
  localparam int PW = INT_IN_DATA_WIDTH + INT_WEIGHT_WIDTH + 1,
  localparam int CW = $clog2(INT_MAX_SHOTS + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_valid,
  input  logic signed [INT_IN_DATA_WIDTH-1:0] i_data_i,
  input  logic signed [INT_IN_DATA_WIDTH-1:0] i_data_q,
  input  logic                                i_cfg_cmd_valid,
  input  logic [1:0]                          i_cfg_cmd_sel,
  input  logic signed [PW-1:0]                i_cfg_cmd_data,
  output logic                                o_state_valid,
  output logic                                o_state,
`ifdef IQ_DISC_PROJ_TAP_EN
  output logic                                o_proj_valid,
  output logic signed [PW-1:0]                o_proj,
`endif
  output logic                                o_cnt_valid,
  output logic [CW-1:0]                       o_cnt_data,
  input  logic                                i_cnt_ready,
  output logic                                o_fifo_full,
  output logic                                o_overflow
);
  localparam int WW = INT_WEIGHT_WIDTH;
  localparam int MW = INT_IN_DATA_WIDTH + INT_WEIGHT_WIDTH;
  localparam int AW = $clog2(INT_FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic signed [PW-1:0] ONE_S = PW'(1);
  localparam logic signed [PW-1:0] MAX_S = PW'(INT_MAX_SHOTS);
  localparam logic [CW-1:0] MAX_C = CW'(INT_MAX_SHOTS);
  localparam logic [NW-1:0] DEPTH_C = NW'(INT_FIFO_DEPTH);

  logic signed [WW-1:0] w_i_q, w_q_q;
  logic signed [PW-1:0] thr_q, thr1_q, proj_d;
  logic signed [MW-1:0] pi_q, pq_q;
  logic [CW-1:0] shots_q, shots_d, shot_q, ones_q, shot_n, ones_n;
  logic v1_q, v2_q, v3_q, gt_q, st_q;
  logic [CW-1:0] mem [INT_FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q, cnt_d;
  logic full_q, ovf_q, shots_wr, push, push_ok, pop;

  assign shots_wr = i_cfg_cmd_valid && i_cfg_cmd_sel == 2'd3;
  assign shots_d = i_cfg_cmd_data < ONE_S ? CW'(1) : i_cfg_cmd_data > MAX_S ? MAX_C : i_cfg_cmd_data[CW-1:0];

  // Config registers; writes land at the next edge so they apply to points accepted afterwards.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_i_q <= WW'(1);
      w_q_q <= '0;
      thr_q <= '0;
      shots_q <= CW'(1);
    end else if (i_cfg_cmd_valid) begin
      if (i_cfg_cmd_sel == 2'd0) w_i_q <= i_cfg_cmd_data[WW-1:0];
      if (i_cfg_cmd_sel == 2'd1) w_q_q <= i_cfg_cmd_data[WW-1:0];
      if (i_cfg_cmd_sel == 2'd2) thr_q <= i_cfg_cmd_data;
      if (shots_wr) shots_q <= shots_d;
    end

  assign proj_d = $signed({pi_q[MW-1], pi_q}) + $signed({pq_q[MW-1], pq_q});

  // Three-stage projection pipeline; the threshold is captured with the point so later writes never touch it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      gt_q <= 1'b0;
      st_q <= 1'b0;
      pi_q <= '0;
      pq_q <= '0;
      thr1_q <= '0;
    end else begin
      v1_q <= i_valid;
      pi_q <= MW'(i_data_i) * MW'(w_i_q);
      pq_q <= MW'(i_data_q) * MW'(w_q_q);
      thr1_q <= thr_q;
      v2_q <= v1_q;
      gt_q <= proj_d > thr1_q;
      v3_q <= v2_q;
      st_q <= v2_q & gt_q;
    end

  assign shot_n = shot_q + CW'(1);
  assign ones_n = ones_q + CW'(st_q);
  assign push = v3_q && !shots_wr && shot_n == shots_q;

  // Batch counters; a shots write discards the partial batch, including a shot arriving in the same cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shot_q <= '0;
      ones_q <= '0;
    end else if (shots_wr) begin
      shot_q <= '0;
      ones_q <= '0;
    end else if (v3_q) begin
      shot_q <= push ? '0 : shot_n;
      ones_q <= push ? '0 : ones_n;
    end

  assign pop = cnt_q != '0 && i_cnt_ready;
  assign push_ok = push && (cnt_q != DEPTH_C || pop);
  assign cnt_d = cnt_q + NW'(push_ok) - NW'(pop);

  // FIFO pointers, occupancy and status; a full FIFO with a same-cycle pop still accepts the push.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_q + AW'(push_ok);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
      full_q <= cnt_d == DEPTH_C;
      ovf_q <= ovf_q | (push & ~push_ok);
    end

  // FIFO storage; contents need no reset because reads are masked while empty.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_q] <= ones_n;

  assign o_state_valid = v3_q;
  assign o_state = st_q;
  assign o_cnt_valid = cnt_q != '0;
  assign o_cnt_data = o_cnt_valid ? mem[rd_q] : '0;
  assign o_fifo_full = full_q;
  assign o_overflow = ovf_q;

`ifdef IQ_DISC_PROJ_TAP_EN
  logic signed [PW-1:0] proj2_q, proj3_q;
  // Projection tap, delayed once more so it lines up with the state strobe.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      proj2_q <= '0;
      proj3_q <= '0;
    end else begin
      proj2_q <= proj_d;
      proj3_q <= v2_q ? proj2_q : '0;
    end
  assign o_proj_valid = v3_q;
  assign o_proj = proj3_q;
`endif
endmodule
